// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: shares the SD-card spi2 master and chip-select between port A (Z80) and port B (AVR).
// Optional idle-timeout revocation is compiled in when SDARB_TIMEOUT_EN is defined.
module sd_spi_arbiter #(
  parameter int unsigned CS_GAP    = 2,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       b_req,
  output logic       a_gnt,
  output logic       b_gnt,
  input  logic       a_start,
  input  logic       b_start,
  input  logic [7:0] a_din,
  input  logic [7:0] b_din,
  input  logic       a_cs_n,
  input  logic       b_cs_n,
  output logic [7:0] a_dout,
  output logic [7:0] b_dout,
  output logic       a_done,
  output logic       b_done,
  output logic       spi_start,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_dout,
  input  logic       spi_rdy,
  output logic       sd_cs_n,
  output logic [1:0] owner
);

  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT1, WAITRDY, RELEASE} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  localparam int unsigned GAP_W = (CS_GAP < 2) ? 1 : $clog2(CS_GAP);

  if (CS_GAP < 1 || TIMEOUT_W < 1) begin : g_param_check
    $error("sd_spi_arbiter: CS_GAP and TIMEOUT_W must both be at least 1");
  end

  state_t           state, state_nxt;
  port_t            own, own_nxt;
  port_t            last, last_nxt;
  logic             a_gnt_nxt, b_gnt_nxt;
  logic             spi_start_nxt;
  logic [7:0]       spi_din_nxt;
  logic             sd_cs_n_nxt;
  logic [7:0]       a_dout_nxt, b_dout_nxt;
  logic             a_done_nxt, b_done_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  logic       own_req, own_start, own_cs_n;
  logic [7:0] own_din;
  logic       a_eff, b_eff;
  logic       accept, revoke, timeout;

  assign own_req   = (own == PORT_A) ? a_req   : b_req;
  assign own_start = (own == PORT_A) ? a_start : b_start;
  assign own_cs_n  = (own == PORT_A) ? a_cs_n  : b_cs_n;
  assign own_din   = (own == PORT_A) ? a_din   : b_din;

  // An accepted start outranks a req drop or a timeout in the same cycle.
  assign accept = own_start & spi_rdy;
  assign revoke = ~own_start & (~own_req | timeout);

  assign owner = {b_gnt, a_gnt};

`ifdef SDARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt, to_cnt_nxt;
  logic                 a_blk, b_blk, a_blk_nxt, b_blk_nxt;

  assign timeout = &to_cnt;
  assign a_eff   = a_req & ~a_blk;
  assign b_eff   = b_req & ~b_blk;

  always_comb begin
    to_cnt_nxt = to_cnt;
    a_blk_nxt  = a_blk & a_req;
    b_blk_nxt  = b_blk & b_req;
    if (state == IDLE || (state == GRANT && accept)) begin
      to_cnt_nxt = '0;
    end else if (state == GRANT && !revoke && !timeout) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end
    // Only a timeout revocation (req still high) blocks the port.
    if (state == GRANT && !accept && revoke && own_req) begin
      if (own == PORT_A) a_blk_nxt = 1'b1;
      else               b_blk_nxt = 1'b1;
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      a_blk  <= 1'b0;
      b_blk  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      a_blk  <= a_blk_nxt;
      b_blk  <= b_blk_nxt;
    end
  end
`else
  assign timeout = 1'b0;
  assign a_eff   = a_req;
  assign b_eff   = b_req;
`endif

  always_comb begin
    state_nxt     = state;
    own_nxt       = own;
    last_nxt      = last;
    a_gnt_nxt     = a_gnt;
    b_gnt_nxt     = b_gnt;
    spi_start_nxt = 1'b0;
    spi_din_nxt   = spi_din;
    sd_cs_n_nxt   = sd_cs_n;
    a_dout_nxt    = a_dout;
    b_dout_nxt    = b_dout;
    a_done_nxt    = 1'b0;
    b_done_nxt    = 1'b0;
    gap_nxt       = gap_cnt;

    case (state)
      IDLE: begin
        sd_cs_n_nxt = 1'b1;
        if (a_eff || b_eff) begin
          if (a_eff && (!b_eff || last == PORT_B)) begin
            own_nxt   = PORT_A;
            last_nxt  = PORT_A;
            a_gnt_nxt = 1'b1;
          end else begin
            own_nxt   = PORT_B;
            last_nxt  = PORT_B;
            b_gnt_nxt = 1'b1;
          end
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        sd_cs_n_nxt = own_cs_n;
        if (accept) begin
          spi_din_nxt   = own_din;
          spi_start_nxt = 1'b1;
          state_nxt     = LAUNCH;
        end else if (revoke) begin
          a_gnt_nxt   = 1'b0;
          b_gnt_nxt   = 1'b0;
          sd_cs_n_nxt = 1'b1;
          gap_nxt     = '0;
          state_nxt   = RELEASE;
        end
      end

      LAUNCH: state_nxt = WAIT1;

      // spi2 may still show rdy from before the start pulse landed.
      WAIT1: state_nxt = WAITRDY;

      WAITRDY: begin
        if (spi_rdy) begin
          if (own == PORT_A) begin
            a_dout_nxt = spi_dout;
            a_done_nxt = 1'b1;
          end else begin
            b_dout_nxt = spi_dout;
            b_done_nxt = 1'b1;
          end
          state_nxt = GRANT;
        end
      end

      RELEASE: begin
        sd_cs_n_nxt = 1'b1;
        if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nxt = IDLE;
        else                               gap_nxt   = gap_cnt + 1'b1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      own       <= PORT_A;
      last      <= PORT_B;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      spi_start <= 1'b0;
      spi_din   <= '0;
      sd_cs_n   <= 1'b1;
      a_dout    <= '0;
      b_dout    <= '0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      own       <= own_nxt;
      last      <= last_nxt;
      a_gnt     <= a_gnt_nxt;
      b_gnt     <= b_gnt_nxt;
      spi_start <= spi_start_nxt;
      spi_din   <= spi_din_nxt;
      sd_cs_n   <= sd_cs_n_nxt;
      a_dout    <= a_dout_nxt;
      b_dout    <= b_dout_nxt;
      a_done    <= a_done_nxt;
      b_done    <= b_done_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

endmodule

// File: doc/sd_spi_arbiter.md
# sd_spi_arbiter

Shares the single SD-card SPI master (spi2 instance plus SD chip-select) between two requesters: port A (Z80 port interface) and port B (AVR slave-SPI register interface, control/data registers 0x61/0x60). Grants exclusive ownership on a level request/grant handshake. Sequences start/rdy to the SPI master on the owner's behalf and routes the received byte back with a done pulse. Forces SD `cs_n` high for a guard gap whenever ownership changes.

## Interface
- `CS_GAP`, 2: cycles `sd_cs_n` is held high in RELEASE before any new grant (≥1).
- `TIMEOUT_W`, 16: idle-timeout counter width; used only with `SDARB_TIMEOUT_EN`.

- `fclk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `a_req` / `b_req` in 1: level ownership request.
- `a_gnt` / `b_gnt` out 1: ownership granted (registered, never both high).
- `a_start` / `b_start` in 1: one-cycle byte-transfer request.
- `a_din` / `b_din` in 8: byte to send, sampled on accepted start.
- `a_cs_n` / `b_cs_n` in 1: requester's desired SD chip-select.
- `a_dout` / `b_dout` out 8: last received byte, held until next completion for that port.
- `a_done` / `b_done` out 1: one-cycle pulse when `*_dout` updates.
- `spi_start` out 1: start pulse to spi2.
- `spi_din` out 8: byte to spi2.
- `spi_dout` in 8: byte from spi2.
- `spi_rdy` in 1: spi2 idle.
- `sd_cs_n` out 1: SD card chip-select.
- `owner` out 2: 00 none, 01 A, 10 B (debug/status readback).

## Operation
- States: IDLE, GRANT, LAUNCH, WAIT1, WAITRDY, RELEASE. An `own` register (A/B) is valid in all states except IDLE.
- Reset: IDLE; `a_gnt=b_gnt=0`, `spi_start=0`, `spi_din=0`, `sd_cs_n=1`, `a_dout=b_dout=0`, `a_done=b_done=0`, `owner=00`, `last=B`.
- IDLE:
  - `sd_cs_n=1`.
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the port ≠ `last` (round-robin). The first tie after reset goes to A.
  - Grant sets `own`, `last`, `*_gnt`; next state GRANT.
- GRANT:
  - `sd_cs_n` follows the owner's `*_cs_n` (registered, 1-cycle lag).
  - Owner start with `spi_rdy=1`: latch owner `*_din` into `spi_din`; go to LAUNCH.
  - Owner start with `spi_rdy=0`: dropped, no done.
  - Owner `req` low and no start that cycle: go to RELEASE.
  - A start and a `req` drop in the same cycle: the start wins; release follows after completion.
- LAUNCH: `spi_start=1` for exactly this cycle; go to WAIT1.
- WAIT1: `spi_rdy` ignored (spi2 may not have dropped it yet); go to WAITRDY.
- WAITRDY:
  - On `spi_rdy=1`: capture `spi_dout` into owner `*_dout`, pulse owner `*_done`, go to GRANT.
  - `req` dropping here does not abort; the transfer completes and done still pulses.
- RELEASE:
  - Clear both `*_gnt` on entry; `sd_cs_n=1`.
  - Count `CS_GAP` cycles, then go to IDLE.
  - A requester is re-granted only through IDLE arbitration.
- Non-owner `start`, `din`, `cs_n`: ignored entirely.
- `owner` mirrors `{b_gnt,a_gnt}`.
- `rst_n` low in any state (mid-transfer included): next edge returns to the reset values.
  - No done pulse for the aborted byte.
  - spi2 is not reset by this block.

## Timing
- `req` to `gnt`: req sampled in IDLE → `gnt` high the next cycle. The minimum is 1 cycle when already in IDLE.
- Accepted start to `spi_start`: 1 cycle.
- `spi_start` to done: 2 cycles + spi2 transfer time. Done is asserted the cycle after `spi_rdy` is sampled high in WAITRDY.
- Back-to-back bytes: the next start is accepted in the cycle after done (GRANT).
- `req` drop to `gnt` low: 1 cycle (if in GRANT).
- Ownership change: `sd_cs_n` high ≥ `CS_GAP`+1 cycles between owners.

## Configuration
- `SDARB_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit counter clears on grant and on every accepted start, and counts in GRANT only.
  - At all-ones it forces RELEASE.
  - A revoked port is blocked from re-grant until its `req` has been seen low for ≥1 cycle.
- `SDARB_TIMEOUT_EN` undefined: no counter, no block flag; grant is held indefinitely while `req` stays high.

## Test plan
- Reset, then `a_req=1` → `a_gnt=1` one cycle later, `owner=01`, `b_gnt=0`. Then `a_cs_n=0` → `sd_cs_n=0` one cycle later.
- A owns; `a_start` with `a_din=8'h41`; spi model returns `8'h5A` → `spi_start` pulses once with `spi_din=8'h41`, then `a_done` one cycle with `a_dout=8'h5A`; `b_dout` stays 0.
- A owns, `b_req=1` and `b_start` pulsed → no `spi_start`, `b_gnt=0`. Then `a_req=0` → `sd_cs_n=1` for 3 cycles (`CS_GAP=2`), then `b_gnt=1`.
- `a_req` and `b_req` rise in the same cycle after reset → A granted. A releases while B still requests → B granted. B releases with A requesting again, and both then tie → A granted.
- Owner drops `req` during WAITRDY → done still pulses with the received byte, then RELEASE. Assert `rst_n=0` during WAITRDY → all outputs back to reset values next edge, no done.
- With `SDARB_TIMEOUT_EN`, `TIMEOUT_W=4`: B granted, idle 15 cycles → `b_gnt` falls. With `b_req` held high, no regrant. After `b_req` goes low for 1 cycle and high again → regranted.
